// File: rtl/column_arbiter_rr.sv
// Round-robin column arbiter with valid/ready grant handshake, masked sweep or
// fixed-priority selection, optional automatic sweep wrap and a saturating accept counter.
module column_arbiter_rr #(
   parameter int N_COLS    = 4,
   parameter int ADDR_W    = $clog2(N_COLS),
   parameter bit AUTO_WRAP = 1'b0,
   parameter int CNT_W     = ADDR_W + 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              enable_i,
   input  logic              refresh_i,
   input  logic              mode_i,
   input  logic [N_COLS-1:0] req_i,
   input  logic              gnt_ready_i,
   output logic [N_COLS-1:0] gnt_o,
   output logic              gnt_valid_o,
   output logic [ADDR_W-1:0] yadd_o,
   output logic              grp_release_o,
   output logic [CNT_W-1:0]  gnt_count_o
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state, state_nxt;
   logic [N_COLS-1:0]   mask_ff, mask_nxt;
   logic [N_COLS-1:0]   gnt_nxt;
   logic [ADDR_W-1:0]   yadd_nxt;
   logic                vld_nxt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic [N_COLS-1:0]   mask_req;
   logic [N_COLS-1:0]   accept_mask;
   logic [N_COLS-1:0]   gnt_shift;

   function automatic logic [N_COLS-1:0] lowest_bit(input logic [N_COLS-1:0] v);
      return v & (~v + N_COLS'(1));
   endfunction

   function automatic logic [ADDR_W-1:0] index_of(input logic [N_COLS-1:0] onehot);
      logic [ADDR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_COLS; i++) begin
         if (onehot[i]) idx = ADDR_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign mask_req      = req_i & mask_ff;
   assign grp_release_o = (state == IDLE) && (mask_req == '0);

   // Mask after an accept: only columns strictly above the granted one stay eligible
   // in sweep mode; the top column shifts out so the mask correctly becomes zero.
   assign gnt_shift   = gnt_o << 1;
   assign accept_mask = mode_i ? '1 : ~(gnt_shift - N_COLS'(1));

   always_comb begin
      state_nxt = state;
      mask_nxt  = mask_ff;
      gnt_nxt   = gnt_o;
      yadd_nxt  = yadd_o;
      vld_nxt   = gnt_valid_o;
      cnt_nxt   = gnt_count_o;
      if (refresh_i) begin
         state_nxt = IDLE;
         mask_nxt  = '1;
         gnt_nxt   = '0;
         yadd_nxt  = '0;
         vld_nxt   = 1'b0;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable_i && (mask_req != '0)) begin
                  gnt_nxt   = lowest_bit(mask_req);
                  yadd_nxt  = index_of(lowest_bit(mask_req));
                  vld_nxt   = 1'b1;
                  state_nxt = HOLD;
               end else if (AUTO_WRAP && enable_i && (req_i != '0)) begin
                  mask_nxt  = '1;
                  gnt_nxt   = lowest_bit(req_i);
                  yadd_nxt  = index_of(lowest_bit(req_i));
                  vld_nxt   = 1'b1;
                  state_nxt = HOLD;
               end
            end
            HOLD: begin
               if (gnt_ready_i) begin
                  cnt_nxt  = sat_inc(gnt_count_o);
                  mask_nxt = accept_mask;
                  if (enable_i && ((req_i & accept_mask) != '0)) begin
                     gnt_nxt  = lowest_bit(req_i & accept_mask);
                     yadd_nxt = index_of(lowest_bit(req_i & accept_mask));
                     vld_nxt  = 1'b1;
                  end else begin
                     gnt_nxt   = '0;
                     yadd_nxt  = '0;
                     vld_nxt   = 1'b0;
                     state_nxt = IDLE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state       <= IDLE;
         mask_ff     <= '1;
         gnt_o       <= '0;
         yadd_o      <= '0;
         gnt_valid_o <= 1'b0;
         gnt_count_o <= '0;
      end else begin
         state       <= state_nxt;
         mask_ff     <= mask_nxt;
         gnt_o       <= gnt_nxt;
         yadd_o      <= yadd_nxt;
         gnt_valid_o <= vld_nxt;
         gnt_count_o <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_column_arbiter_rr.sv
// Bench for column_arbiter_rr: two instances (no wrap / auto wrap) share stimulus and
// are compared each cycle against a sweep-pointer reference model.
module tb_column_arbiter_rr;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       enable_i = 1'b0;
   logic       refresh_i = 1'b0;
   logic       mode_i = 1'b0;
   logic [3:0] req_i = '0;
   logic       gnt_ready_i = 1'b0;

   logic [3:0] gnt0, gnt1;
   logic       vld0, vld1, rel0, rel1;
   logic [1:0] yadd0, yadd1;
   logic [2:0] cnt0, cnt1;

   int total = 0;
   int bad = 0;

   // Reference model: sweep pointer (first eligible column) instead of a bit mask.
   bit wrap[2] = '{1'b0, 1'b1};
   bit busy[2];
   int gidx[2];
   int ptr[2];
   int cnt[2];

   always #5 clk_i = ~clk_i;

   column_arbiter_rr #(.N_COLS(4), .AUTO_WRAP(1'b0)) dut0 (
      .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .refresh_i(refresh_i),
      .mode_i(mode_i), .req_i(req_i), .gnt_ready_i(gnt_ready_i), .gnt_o(gnt0),
      .gnt_valid_o(vld0), .yadd_o(yadd0), .grp_release_o(rel0), .gnt_count_o(cnt0));

   column_arbiter_rr #(.N_COLS(4), .AUTO_WRAP(1'b1)) dut1 (
      .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .refresh_i(refresh_i),
      .mode_i(mode_i), .req_i(req_i), .gnt_ready_i(gnt_ready_i), .gnt_o(gnt1),
      .gnt_valid_o(vld1), .yadd_o(yadd1), .grp_release_o(rel1), .gnt_count_o(cnt1));

   function automatic int find_from(input logic [3:0] r, input int p);
      for (int j = p; j < 4; j++) if (r[j]) return j;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         busy[d] = 1'b0; gidx[d] = 0; ptr[d] = 0; cnt[d] = 0;
      end
   endtask

   task automatic model_step();
      int j;
      for (int d = 0; d < 2; d++) begin
         if (refresh_i) begin
            busy[d] = 1'b0; ptr[d] = 0; cnt[d] = 0;
         end else if (!busy[d]) begin
            j = find_from(req_i, ptr[d]);
            if (enable_i && j >= 0) begin
               busy[d] = 1'b1; gidx[d] = j;
            end else if (wrap[d] && enable_i && req_i != 0) begin
               ptr[d] = 0; busy[d] = 1'b1; gidx[d] = find_from(req_i, 0);
            end
         end else if (gnt_ready_i) begin
            cnt[d] = (cnt[d] < 7) ? cnt[d] + 1 : 7;
            ptr[d] = mode_i ? 0 : gidx[d] + 1;
            busy[d] = 1'b0;
            j = find_from(req_i, ptr[d]);
            if (enable_i && j >= 0) begin
               busy[d] = 1'b1; gidx[d] = j;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [3:0] eg;
      for (int d = 0; d < 2; d++) begin
         eg = busy[d] ? 4'(1 << gidx[d]) : 4'b0;
         chk($sformatf("d%0d_gnt", d),   32'(d ? gnt1 : gnt0), 32'(eg));
         chk($sformatf("d%0d_vld", d),   32'(d ? vld1 : vld0), 32'(busy[d]));
         chk($sformatf("d%0d_yadd", d),  32'(d ? yadd1 : yadd0), busy[d] ? 32'(gidx[d]) : 32'd0);
         chk($sformatf("d%0d_rel", d),   32'(d ? rel1 : rel0),
             32'(!busy[d] && find_from(req_i, ptr[d]) < 0));
         chk($sformatf("d%0d_cnt", d),   32'(d ? cnt1 : cnt0), 32'(cnt[d]));
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_refresh();
      refresh_i = 1'b1;
      tick();
      refresh_i = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk_i);
      check_all();
      chk("reset_release", 32'(rel0), 32'd1);
      reset_i = 1'b0;

      // Sweep over 1011 with ready held high.
      enable_i = 1'b1; mode_i = 1'b0; gnt_ready_i = 1'b1; req_i = 4'b1011;
      tick(); chk("sweep_g0", 32'(gnt0), 32'h1); chk("sweep_y0", 32'(yadd0), 32'd0);
      tick(); chk("sweep_g1", 32'(gnt0), 32'h2); chk("sweep_y1", 32'(yadd0), 32'd1);
      tick(); chk("sweep_g2", 32'(gnt0), 32'h8); chk("sweep_y2", 32'(yadd0), 32'd3);
      tick(); chk("sweep_rel", 32'(rel0), 32'd1); chk("sweep_cnt", 32'(cnt0), 32'd3);
      tick(); chk("sweep_stays_rel", 32'(rel0), 32'd1);

      // Backpressure with the request dropped while held.
      do_refresh();
      gnt_ready_i = 1'b0; req_i = 4'b0100;
      tick();
      req_i = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         tick(); chk("bp_gnt", 32'(gnt0), 32'h4); chk("bp_yadd", 32'(yadd0), 32'd2);
      end
      gnt_ready_i = 1'b1;
      tick(); chk("bp_cnt", 32'(cnt0), 32'd1); chk("bp_vld", 32'(vld0), 32'd0);

      // Fixed priority.
      do_refresh();
      mode_i = 1'b1; req_i = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         tick(); chk("fp_gnt", 32'(gnt0), 32'h1); chk("fp_rel", 32'(rel0), 32'd0);
      end

      // Wrap versus no wrap on 1001.
      mode_i = 1'b0;
      do_refresh();
      req_i = 4'b1001;
      for (int i = 0; i < 9; i++) tick();
      chk("nowrap_rel", 32'(rel0), 32'd1);
      chk("nowrap_cnt", 32'(cnt0), 32'd2);

      // Refresh coinciding with ready drops the pending grant uncounted.
      do_refresh();
      gnt_ready_i = 1'b0; req_i = 4'b0001;
      tick();
      gnt_ready_i = 1'b1; refresh_i = 1'b1;
      tick(); refresh_i = 1'b0;
      chk("rfr_cnt", 32'(cnt0), 32'd0); chk("rfr_vld", 32'(vld0), 32'd0);

      // Counter saturation: 9 accepts.
      mode_i = 1'b1; req_i = 4'b0001; gnt_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("sat_cnt", 32'(cnt0), 32'd7);

      // Async reset mid-HOLD, between edges.
      gnt_ready_i = 1'b0; req_i = 4'b0100; mode_i = 1'b0;
      do_refresh();
      tick();
      #2 reset_i = 1'b1;
      #1 model_reset();
      check_all();
      chk("arst_vld", 32'(vld0), 32'd0);
      #1 reset_i = 1'b0;

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         req_i       = 4'($urandom_range(0, 15));
         enable_i    = ($urandom_range(0, 7) != 0);
         mode_i      = ($urandom_range(0, 3) == 0);
         gnt_ready_i = ($urandom_range(0, 2) != 0);
         refresh_i   = ($urandom_range(0, 31) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/column_arbiter_rr.md
# column_arbiter_rr

Parametrised round-robin column arbiter with a valid/ready grant handshake. It is the successor to the single-sweep column arbiter used under the row arbiter in the pixel hierarchy. It grants one active column per transaction and holds the grant stable until the downstream encoder accepts it. Two modes are added: a masked sweep mode and a fixed-priority mode. An optional automatic wrap restarts the sweep without an external refresh, and an accepted-grant counter reports how many grants were taken.

## Interface
- N_COLS, 4: number of column request lines; must be ≥ 2.
- ADDR_W, $clog2(N_COLS): width of the encoded column index.
- AUTO_WRAP, 0: 1 = reload the mask automatically when the sweep is exhausted and requests remain.
- CNT_W, ADDR_W+1: width of the accepted-grant counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  arbitration enable; no new grant is issued while low.
- refresh_i  in  1  synchronous re-initialisation of the mask, grant and counter.
- mode_i  in  1  0 = round-robin sweep; 1 = fixed priority (lowest index wins).
- req_i  in  N_COLS  column requests, level-sensitive.
- gnt_ready_i  in  1  downstream accepts the current grant.
- gnt_o  out  N_COLS  one-hot registered grant.
- gnt_valid_o  out  1  gnt_o and yadd_o are valid.
- yadd_o  out  ADDR_W  registered index of the set bit of gnt_o.
- grp_release_o  out  1  sweep exhausted: no masked requests remain.
- gnt_count_o  out  CNT_W  accepted grants since reset/refresh; saturates at all-ones.

## Operation
- Registers:
  - mask_ff: reset value all ones.
  - state: IDLE or HOLD.
  - gnt_o, yadd_o, gnt_valid_o, gnt_count_o.
- Derived signals: mask_req = req_i & mask_ff; pick = lowest set bit of mask_req.
- IDLE state:
  - If enable_i is high and mask_req != 0: register gnt_o = pick, yadd_o = index(pick), gnt_valid_o = 1; go to HOLD.
  - If AUTO_WRAP=1, enable_i is high, mask_req == 0 and req_i != 0: arbitrate on req_i as if mask_ff were all ones. mask_ff is reloaded to all ones in the same cycle.
- HOLD state:
  - gnt_o, yadd_o and gnt_valid_o are frozen.
  - Requests that drop during HOLD do not revoke the grant.
  - On gnt_ready_i: gnt_count_o increments, saturating.
  - On gnt_ready_i, mode_i is sampled and the mask updates:
    - mode 0: mask_ff = bits strictly above the granted index, i.e. ~((gnt_o<<1)-1).
    - mode 1: mask_ff = all ones.
  - Back-to-back: in the accept cycle, if enable_i is high and (req_i & new mask) != 0, the next grant is registered directly and the block stays in HOLD. Otherwise gnt_o = 0, yadd_o = 0, gnt_valid_o = 0, and the block returns to IDLE.
- grp_release_o = (state == IDLE) & (mask_req == 0). It is combinational and is never asserted in HOLD.
- Priority: reset_i > refresh_i > handshake/arbitration.
- refresh_i, in either state:
  - mask_ff = all ones; gnt_o = 0, yadd_o = 0, gnt_valid_o = 0; gnt_count_o = 0; state = IDLE.
  - An outstanding grant is dropped without being counted.
- enable_i low in HOLD does not block acceptance; it only blocks issuing a new grant.

## Timing
- Reset (asynchronous): mask_ff = all ones; gnt_o = 0; yadd_o = 0; gnt_valid_o = 0; gnt_count_o = 0; state = IDLE. grp_release_o = (req_i == 0).
- Grant latency: request seen in IDLE with enable_i at edge N → gnt_valid_o high after edge N.
- Acceptance happens at an edge where gnt_valid_o & gnt_ready_i are both high. The counter and mask update at that same edge.
- Throughput: one grant per cycle while gnt_ready_i is held high and masked requests remain.
- Sweep end, AUTO_WRAP=0: grp_release_o stays high until refresh_i, even if requests reappear below the mask.
- Index width: yadd_o is exactly ADDR_W bits wide, e.g. N_COLS=5 gives ADDR_W=3 with values 0..4.
- Counter: at all-ones, further accepts leave it unchanged.

## Test plan
- Sweep: N_COLS=4, mode 0, req_i=4'b1011, ready=1, enable=1 → gnt_o sequence 0001, 0010, 1000 on consecutive cycles; yadd_o 0, 1, 3; then IDLE with grp_release_o=1; gnt_count_o=3.
- Backpressure: hold ready=0 for 5 cycles after a grant of 0100, and drop req_i[2] meanwhile → gnt_o=0100 and yadd_o=2 stay stable with valid high; the grant is accepted once ready=1.
- Fixed priority: mode 1, req_i=4'b0011 held → every accepted grant is 0001; grp_release_o never asserts.
- Wrap: AUTO_WRAP=1 with req_i=4'b1001 → grants 0001, 1000, 0001, 1000 … with no refresh needed. The same stimulus with AUTO_WRAP=0 stops after 1000 with grp_release_o=1.
- Refresh during HOLD with a grant pending → next cycle all outputs are 0, gnt_count_o=0, and mask_ff is all ones. Refresh and ready in the same cycle → refresh wins, and the grant is not counted.
- Async reset asserted mid-HOLD, between clock edges → outputs clear immediately. Counter saturation: CNT_W=3 with 9 accepts → gnt_count_o=7.
